// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: multi-cycle Gray->binary decoder that reuses one 4-bit nibble stage, MSB nibble first.
// Defining GRAY_SEQ_ENC_EN adds port in_mode, which selects binary->Gray encode with the same timing.
module gray_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
`ifdef GRAY_SEQ_ENC_EN
    input  logic             in_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic             par;
    logic [CW-1:0]    cnt;
    logic             mode;
    logic [3:0]       nib_in;
    logic [3:0]       nib_out;
    logic             par_next;

    assign in_ready = (state == IDLE);
    assign nib_in   = word[4*cnt +: 4];

`ifndef GRAY_SEQ_ENC_EN
    assign mode = 1'b0;
`endif

    // Shared nibble stage; par carries the running prefix parity from the nibble above.
    always_comb begin
        nib_out  = 4'd0;
        par_next = 1'b0;
        if (mode) begin
            nib_out[3] = nib_in[3] ^ par;
            nib_out[2] = nib_in[3] ^ nib_in[2];
            nib_out[1] = nib_in[2] ^ nib_in[1];
            nib_out[0] = nib_in[1] ^ nib_in[0];
            par_next   = nib_in[0];
        end else begin
            nib_out[3] = nib_in[3] ^ par;
            nib_out[2] = nib_out[3] ^ nib_in[2];
            nib_out[1] = nib_out[2] ^ nib_in[1];
            nib_out[0] = nib_out[1] ^ nib_in[0];
            par_next   = nib_out[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            par       <= 1'b0;
            cnt       <= '0;
            out_bin   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef GRAY_SEQ_ENC_EN
            mode      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= in_gray;
                        par   <= 1'b0;
                        cnt   <= LAST;
                        busy  <= 1'b1;
                        state <= CONV;
`ifdef GRAY_SEQ_ENC_EN
                        mode  <= in_mode;
`endif
                    end
                end
                CONV: begin
                    out_bin[4*cnt +: 4] <= nib_out;
                    par <= par_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Held here indefinitely under backpressure; no new word is taken on the handshake edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed and random checks of gray_seq_ctrl at WIDTH=4 and WIDTH=16.
// Encode-mode vectors are included when GRAY_SEQ_ENC_EN is defined.
module tb_gray_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [3:0]  ig4, ob4;
    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] ig16, ob16;
    logic        md4, md16;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    gray_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_gray(ig4),
`ifdef GRAY_SEQ_ENC_EN
        .in_mode(md4),
`endif
        .out_valid(ov4), .out_ready(or4), .out_bin(ob4), .busy(busy4)
    );

    gray_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_gray(ig16),
`ifdef GRAY_SEQ_ENC_EN
        .in_mode(md16),
`endif
        .out_valid(ov16), .out_ready(or16), .out_bin(ob16), .busy(busy16)
    );

    function automatic logic [15:0] g2b(input logic [15:0] g, input int w);
        logic [15:0] b;
        b = '0;
        b[w-1] = g[w-1];
        for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One full transaction on the 16-bit instance, including latency and handshake checks.
    task automatic applyStimulus(input logic [15:0] g, input logic md, input logic [15:0] exp,
                                 input string tag, output logic [15:0] res);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!ir16 && n < 50) begin @(negedge clk); n++; end
        checkOutput({tag, "_ready"}, {31'd0, ir16}, 32'd1);
        iv16 = 1'b1; ig16 = g; md16 = md;
        @(negedge clk);
        iv16 = 1'b0; ig16 = 16'hDEAD; md16 = ~md;
        lat = 0;
        while (!ov16 && lat < 50) begin @(negedge clk); lat++; end
        checkOutput({tag, "_lat"}, lat, 32'd4);
        checkOutput({tag, "_bin"}, {16'd0, ob16}, {16'd0, exp});
        checkOutput({tag, "_busy_irdy"}, {30'd0, busy16, ir16}, 32'd2);
        res = ob16;
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        checkOutput({tag, "_release"}, {29'd0, ov16, busy16, ir16}, 32'd1);
    endtask

    task automatic applyStimulus4(input logic [3:0] g, input logic [3:0] exp, input string tag);
        int lat;
        @(negedge clk);
        iv4 = 1'b1; ig4 = g;
        @(negedge clk);
        iv4 = 1'b0; ig4 = ~g;
        lat = 0;
        while (!ov4 && lat < 20) begin @(negedge clk); lat++; end
        checkOutput({tag, "_lat"}, lat, 32'd1);
        checkOutput({tag, "_bin"}, {28'd0, ob4}, {28'd0, exp});
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        checkOutput({tag, "_release"}, {29'd0, ov4, busy4, ir4}, 32'd1);
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] g;
        logic [15:0] held;
        logic        hs;
        int          n;

        rst_n = 1'b0;
        iv4 = 0; ig4 = 0; or4 = 0; md4 = 0;
        iv16 = 0; ig16 = 0; or16 = 0; md16 = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset16", {12'd0, ov16, busy16, ir16, 1'b0, ob16}, {12'd0, 3'b001, 1'b0, 16'h0000});
        checkOutput("reset4", {25'd0, ov4, busy4, ir4, ob4}, {25'd0, 3'b001, 4'h0});
        rst_n = 1'b1;

        // T1: WIDTH=4
        applyStimulus4(4'b1000, 4'hF, "t1_1000");
        applyStimulus4(4'b0011, 4'h2, "t1_0011");
        for (int c = 0; c < 16; c++) applyStimulus4(4'(c), g2b(16'(c), 4)[3:0], "t1_all");

        // T2: WIDTH=16
        applyStimulus(16'h8000, 1'b0, 16'hFFFF, "t2_8000", res);
        applyStimulus(16'hC000, 1'b0, 16'h8000, "t2_C000", res);
        applyStimulus(16'h0003, 1'b0, 16'h0002, "t2_0003", res);

        // T3: backpressure with a competing in_valid during DONE
        @(negedge clk);
        iv16 = 1'b1; ig16 = 16'h0F00;
        @(negedge clk);
        ig16 = 16'h1111;
        n = 0;
        while (!ov16 && n < 50) begin @(negedge clk); n++; end
        held = ob16;
        checkOutput("t3_bin", {16'd0, held}, {16'd0, 16'h0A00});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t3_hold", {13'd0, ov16, ir16, busy16, ob16}, {13'd0, 3'b101, held});
        end
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0; iv16 = 1'b0;
        checkOutput("t3_after", {29'd0, ov16, busy16, ir16}, 32'd1);
        @(negedge clk);
        checkOutput("t3_nocapture", {30'd0, busy16, ir16}, 32'd1);

        // T4: reset during the second CONV cycle
        iv16 = 1'b1; ig16 = 16'h1234;
        @(negedge clk);
        iv16 = 1'b0;
        @(negedge clk);
        checkOutput("t4_midconv", {31'd0, busy16}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_reset", {13'd0, ov16, busy16, ir16, ob16}, {13'd0, 3'b001, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0001, 1'b0, 16'h0001, "t4_next", res);

        // T5: random stream with random out_ready
        for (int i = 0; i < 1000; i++) begin
            g = 16'($urandom);
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            iv16 = 1'b1; ig16 = g;
            @(negedge clk);
            iv16 = 1'b0; ig16 = 16'($urandom);
            n = 0;
            hs = 1'b0;
            while (!hs && n < 100) begin
                or16 = 1'($urandom_range(0, 1));
                hs = ov16 && or16;
                if (hs) checkOutput("t5_stream", {16'd0, ob16}, {16'd0, g2b(g, 16)});
                @(negedge clk);
                n++;
            end
            or16 = 1'b0;
            if (!hs) checkOutput("t5_timeout", n, 32'd0);
        end

`ifdef GRAY_SEQ_ENC_EN
        // T6: encode mode and round trip
        applyStimulus(16'hFFFF, 1'b1, 16'h8000, "t6_FFFF", res);
        applyStimulus(16'h0002, 1'b1, 16'h0003, "t6_0002", res);
        applyStimulus(16'hA5C3, 1'b1, 16'hA5C3 ^ 16'h52E1, "t6_enc", res);
        applyStimulus(res, 1'b0, 16'hA5C3, "t6_round", res);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
